// File: rtl/hold_buffer_scheduler_pkg.sv
// rtl/hold_buffer_scheduler_pkg.sv - shared FSM state and CMD frame constants
// Purpose: types and constants shared by the scheduler top and its CMD serializer.
// Ports: none (package).
package hold_buffer_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Every CMD frame opens with this bit so the SURF can find frame start.
  localparam logic CMD_START_BIT = 1'b1;

  // Frame: start bit, buffer number, event ID.
  function automatic int unsigned cmd_frame_len(input int unsigned buf_bits,
                                                input int unsigned evid_width);
    return 1 + buf_bits + evid_width;
  endfunction

endpackage

// File: rtl/hold_buffer_scheduler_cmd_frame_serializer.sv
// rtl/hold_buffer_scheduler_cmd_frame_serializer.sv - serialises one CMD frame MSB first
// Purpose: loads {start, buffer, event ID} on load_i and shifts it out one bit per cycle.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   load_i           start a frame (only honoured while idle)
//   buf_i, evid_i    buffer number and event ID captured on load
//   cmd_o            registered serial CMD bit
//   busy_o           high for exactly the frame cycles
module hold_buffer_scheduler_cmd_frame_serializer
  import hold_buffer_scheduler_pkg::*;
#(
  parameter int BUF_BITS   = 2,
  parameter int EVID_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [BUF_BITS-1:0]   buf_i,
  input  logic [EVID_WIDTH-1:0] evid_i,
  output logic                  cmd_o,
  output logic                  busy_o
);

  localparam int FRAME_LEN = cmd_frame_len(BUF_BITS, EVID_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e               state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // The shifter fills with zeros, so after FRAME_LEN shifts it is empty and
  // cmd_o settles back to 0 without a separate idle-value mux.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (load_i) begin
        shift_d = {CMD_START_BIT, buf_i, evid_i};
        cnt_d   = '0;
        state_d = ST_SEND;
      end
    end else begin
      shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
      if (cnt_q == LAST_CNT) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_o  = shift_q[FRAME_LEN-1];
  assign busy_o = (state_q == ST_SEND);

endmodule

// File: rtl/hold_buffer_scheduler.sv
// rtl/hold_buffer_scheduler.sv - round-robin HOLD allocation and CMD event notification
// Purpose: accepts triggers, holds the next free analog buffer, announces it on CMD,
//          and releases held buffers in FIFO order on clear-event.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   trig_i, evid_i, disable_i  trigger request, event ID, master disable
//   clr_evt_i                  release the oldest held buffer
//   hold_o                     per-buffer HOLD levels
//   cmd_o, cmd_busy_o          serial CMD bit and frame-in-progress flag
//   occupancy_o, next_buf_o    held count and buffer for the next trigger
//   full_o                     all buffers held
//   trig_accept_o, trig_drop_o per-trigger accept/refuse pulses
module hold_buffer_scheduler
  import hold_buffer_scheduler_pkg::*;
#(
  parameter int NBUF       = 4,
  parameter int BUF_BITS   = 2,
  parameter int EVID_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trig_i,
  input  logic [EVID_WIDTH-1:0] evid_i,
  input  logic                  disable_i,
  input  logic                  clr_evt_i,
  output logic [NBUF-1:0]       hold_o,
  output logic                  cmd_o,
  output logic                  cmd_busy_o,
  output logic [BUF_BITS:0]     occupancy_o,
  output logic [BUF_BITS-1:0]   next_buf_o,
  output logic                  full_o,
  output logic                  trig_accept_o,
  output logic                  trig_drop_o
);

  localparam logic [BUF_BITS:0] OCC_FULL = (BUF_BITS + 1)'(NBUF);

  logic [NBUF-1:0]     hold_q, hold_d;
  logic [BUF_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_BITS:0]   occ_q, occ_d;
  logic                do_clr;

  assign full_o = (occ_q == OCC_FULL);

  // Accept and clear never target the same buffer: that would need wr==rd
  // with occupancy>0, which only happens when full, and full blocks accept.
  always_comb begin
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    trig_accept_o = trig_i & ~disable_i & ~full_o & ~cmd_busy_o;
    trig_drop_o   = trig_i & ~trig_accept_o;
    do_clr        = clr_evt_i & (occ_q != '0);

    if (do_clr) begin
      hold_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end
    if (trig_accept_o) begin
      hold_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    if (trig_accept_o && !do_clr) begin
      occ_d = occ_q + 1'b1;
    end else if (do_clr && !trig_accept_o) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  hold_buffer_scheduler_cmd_frame_serializer #(
    .BUF_BITS  (BUF_BITS),
    .EVID_WIDTH(EVID_WIDTH)
  ) u_cmd_ser (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(trig_accept_o),
    .buf_i (wr_ptr_q),
    .evid_i(evid_i),
    .cmd_o (cmd_o),
    .busy_o(cmd_busy_o)
  );

  assign hold_o      = hold_q;
  assign occupancy_o = occ_q;
  assign next_buf_o  = wr_ptr_q;

endmodule

// File: tb/tb_hold_buffer_scheduler.sv
// tb/tb_hold_buffer_scheduler.sv - scoreboard bench for hold_buffer_scheduler
module tb_hold_buffer_scheduler;

  localparam int NBUF = 4;
  localparam int BUF_BITS = 2;
  localparam int EVID_WIDTH = 32;
  localparam int FL = 1 + BUF_BITS + EVID_WIDTH;

  logic clk = 1'b0;
  logic rst_i, trig_i, disable_i, clr_evt_i;
  logic [EVID_WIDTH-1:0] evid_i;
  logic [NBUF-1:0] hold_o;
  logic cmd_o, cmd_busy_o, full_o, trig_accept_o, trig_drop_o;
  logic [BUF_BITS:0] occupancy_o;
  logic [BUF_BITS-1:0] next_buf_o;

  always #5 clk = ~clk;

  hold_buffer_scheduler #(.NBUF(NBUF), .BUF_BITS(BUF_BITS), .EVID_WIDTH(EVID_WIDTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .trig_i(trig_i), .evid_i(evid_i),
    .disable_i(disable_i), .clr_evt_i(clr_evt_i), .hold_o(hold_o), .cmd_o(cmd_o),
    .cmd_busy_o(cmd_busy_o), .occupancy_o(occupancy_o), .next_buf_o(next_buf_o),
    .full_o(full_o), .trig_accept_o(trig_accept_o), .trig_drop_o(trig_drop_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO of held buffer numbers, round-robin next buffer,
  // remaining busy cycles of the current frame, and expected frames.
  int held_q[$];
  int next_buf = 0;
  int busy_rem = 0;
  logic [FL-1:0] exp_q[$];
  bit abandon = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input bit trig, input logic [EVID_WIDTH-1:0] evid, input bit dis,
                      input bit clr, input bit rst);
    bit exp_acc;
    logic [NBUF-1:0] exp_hold;
    trig_i = trig; evid_i = evid; disable_i = dis; clr_evt_i = clr; rst_i = rst;
    #1;
    exp_acc = trig && !dis && (held_q.size() < NBUF) && (busy_rem == 0);
    if (!rst) begin
      exp_hold = '0;
      foreach (held_q[i]) exp_hold[held_q[i]] = 1'b1;
      chk("hold", 64'(hold_o), 64'(exp_hold));
      chk("occupancy", 64'(occupancy_o), 64'(held_q.size()));
      chk("full", 64'(full_o), 64'(held_q.size() == NBUF));
      chk("next_buf", 64'(next_buf_o), 64'(next_buf));
      chk("busy", 64'(cmd_busy_o), 64'(busy_rem > 0));
      chk("accept", 64'(trig_accept_o), 64'(exp_acc));
      chk("drop", 64'(trig_drop_o), 64'(trig && !exp_acc));
    end
    @(posedge clk);
    if (rst) begin
      if (busy_rem > 0) abandon = 1;
      held_q.delete();
      exp_q.delete();
      next_buf = 0;
      busy_rem = 0;
      mon_en = 1;
    end else begin
      if (clr && held_q.size() > 0) void'(held_q.pop_front());
      if (busy_rem > 0) busy_rem--;
      if (exp_acc) begin
        held_q.push_back(next_buf);
        exp_q.push_back({1'b1, BUF_BITS'(next_buf), evid});
        next_buf = (next_buf + 1) % NBUF;
        busy_rem = FL;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
  endtask

  task automatic wait_frame_done();
    int guard = 0;
    while (busy_rem > 0 && guard < 100) begin
      step(0, '0, 0, 0, 0);
      guard++;
    end
  endtask

  // Frame monitor: collects cmd_o while busy and compares whole frames.
  initial begin
    int cnt = 0;
    logic [FL-1:0] cap = '0;
    logic [FL-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (cmd_busy_o === 1'b1) begin
        cap = {cap[FL-2:0], cmd_o};
        cnt++;
      end else begin
        if (cnt > 0) begin
          if (abandon) begin
            abandon = 0;
          end else if (exp_q.size() == 0) begin
            chk("frame_unexpected", 64'(cap), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("frame", 64'(cap), 64'(e));
            chk("frame_len", 64'(cnt), 64'(FL));
          end
          cnt = 0;
        end
        if (mon_en) chk("cmd_idle", 64'(cmd_o), 64'(0));
      end
    end
  end

  initial begin
    trig_i = 0; evid_i = '0; disable_i = 0; clr_evt_i = 0; rst_i = 1;
    @(negedge clk);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    idle(2);

    // Single trigger, full frame.
    step(1, 32'h0000_00A5, 0, 0, 0);
    wait_frame_done();
    idle(1);

    // Fill all buffers, then a refused fifth trigger.
    for (int k = 0; k < 3; k++) begin
      step(1, $urandom, 0, 0, 0);
      wait_frame_done();
    end
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    idle(2);

    // Two clears, then wrap to buffer 0.
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(1, 32'h1234_5678, 0, 0, 0);

    // Trigger during SEND, then trigger while disabled.
    step(1, 32'hFFFF_FFFF, 0, 0, 0);
    wait_frame_done();
    step(1, 32'h5555_AAAA, 1, 0, 0);

    // Drain to occupancy 1, then simultaneous trigger and clear.
    while (held_q.size() > 1) step(0, '0, 0, 1, 0);
    step(1, 32'h0F0F_0F0F, 0, 1, 0);
    wait_frame_done();

    // Clear at occupancy 0 is ignored.
    while (held_q.size() > 0) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    idle(1);

    // Reset mid-frame, then the next trigger takes buffer 0.
    step(1, 32'h8000_0001, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    idle(9);
    step(0, '0, 0, 0, 1);
    idle(1);
    step(1, 32'hC3C3_3C3C, 0, 0, 0);
    wait_frame_done();
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
    end
    wait_frame_done();
    idle(3);
    chk("frames_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
